// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding requests to instruction
// memory, buffers one returned instruction, and presents it to the IF/ID
// register. Redirects flush the buffer and retarget the fetch PC; a response
// still in flight at redirect time is dropped on arrival.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        IF_ID_Write_o,
  output logic        Flush_o
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] fetch_pc_r, fetch_pc_next_s;
  logic        buf_valid_r, buf_valid_next_s;
  logic [31:0] buf_pc_r, buf_pc_next_s;
  logic [31:0] buf_instr_r, buf_instr_next_s;
  logic        req_s;
  logic [31:0] redirect_target_s;

  // Word-aligned redirect target (low two address bits are forced to zero).
  assign redirect_target_s = redirect_pc_i & 32'hFFFF_FFFC;

  // Request generation and IF/ID-facing outputs.
  always_comb begin
    req_s         = 1'b0;
    pc_o          = 32'h0000_0000;
    instruction_o = 32'h0000_0000;
    if (!rst_i && (state_r == ST_FETCH) && !buf_valid_r && !redirect_i) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    if (!rst_i && buf_valid_r) begin
      pc_o          = buf_pc_r;
      instruction_o = buf_instr_r;
    end else begin
      pc_o          = 32'h0000_0000;
      instruction_o = 32'h0000_0000;
    end
    imem_req_o    = req_s;
    imem_addr_o   = fetch_pc_r;
    IF_ID_Write_o = ~stall_i;
    Flush_o       = redirect_i;
  end

  // Next-state logic: redirect has priority, then consume/stall and FSM moves.
  always_comb begin
    state_next_s     = state_r;
    fetch_pc_next_s  = fetch_pc_r;
    buf_valid_next_s = buf_valid_r;
    buf_pc_next_s    = buf_pc_r;
    buf_instr_next_s = buf_instr_r;
    if (redirect_i) begin
      fetch_pc_next_s  = redirect_target_s;
      buf_valid_next_s = 1'b0;
      case (state_r)
        ST_FETCH: state_next_s = ST_FETCH;
        ST_WAIT:  state_next_s = imem_ready_i ? ST_FETCH : ST_DROP;
        ST_DROP:  state_next_s = imem_ready_i ? ST_FETCH : ST_DROP;
        default:  state_next_s = ST_FETCH;
      endcase
    end else begin
      // Buffer is consumed when IF/ID accepts it.
      if (buf_valid_r && !stall_i) begin
        buf_valid_next_s = 1'b0;
      end else begin
        buf_valid_next_s = buf_valid_r;
      end
      case (state_r)
        ST_FETCH: begin
          if (req_s) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_FETCH;
          end
        end
        ST_WAIT: begin
          // A response lands even while stalled: the buffer is empty in WAIT.
          if (imem_ready_i) begin
            buf_pc_next_s    = fetch_pc_r;
            buf_instr_next_s = imem_data_i;
            buf_valid_next_s = 1'b1;
            fetch_pc_next_s  = fetch_pc_r + 32'd4;
            state_next_s     = ST_FETCH;
          end else begin
            state_next_s = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem_ready_i) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_DROP;
          end
        end
        default: state_next_s = ST_FETCH;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_FETCH;
      fetch_pc_r  <= RESET_PC;
      buf_valid_r <= 1'b0;
      buf_pc_r    <= 32'h0000_0000;
      buf_instr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_next_s;
      fetch_pc_r  <= fetch_pc_next_s;
      buf_valid_r <= buf_valid_next_s;
      buf_pc_r    <= buf_pc_next_s;
      buf_instr_r <= buf_instr_next_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Inputs are driven 1 time unit
// after each rising edge; outputs are compared 1 time unit later.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        IF_ID_Write_o;
  logic        Flush_o;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_data_i   (imem_data_i),
    .pc_o          (pc_o),
    .instruction_o (instruction_o),
    .IF_ID_Write_o (IF_ID_Write_o),
    .Flush_o       (Flush_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_ready_i = 1'b0; imem_data_i = 32'h0;
    tick(); tick(); settle();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b exp 0", imem_req_o); end
    checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h exp 00000000", pc_o); end
    checks++; if (instruction_o !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h exp 00000000", instruction_o); end
    rst_i = 1'b0;
    settle();
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL reset_first_req: got %0b exp 1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_first_addr: got %h exp 00000000", imem_addr_o); end
  endtask

  // Request at 0x0 is live on entry.
  task automatic test_basic_fetch();
    tick(); imem_ready_i = 1'b1; imem_data_i = 32'h0050_0093; settle();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL basic_wait_req: got %0b exp 0", imem_req_o); end
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; settle();
    checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL basic_pc: got %h exp 00000000", pc_o); end
    checks++; if (instruction_o !== 32'h0050_0093) begin failures++; $display("FAIL basic_instr: got %h exp 00500093", instruction_o); end
    checks++; if (IF_ID_Write_o !== 1'b1) begin failures++; $display("FAIL basic_write: got %0b exp 1", IF_ID_Write_o); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL basic_full_req: got %0b exp 0", imem_req_o); end
    tick(); settle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin failures++; $display("FAIL basic_next_req: got req=%0b addr=%h exp req=1 addr=00000004", imem_req_o, imem_addr_o); end
    checks++; if (instruction_o !== 32'h0) begin failures++; $display("FAIL basic_bubble: got %h exp 00000000", instruction_o); end
  endtask

  // Request at 0x4 is live on entry.
  task automatic test_stall();
    tick(); imem_ready_i = 1'b1; imem_data_i = 32'h1111_1111; settle();
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; stall_i = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (IF_ID_Write_o !== 1'b0) begin failures++; $display("FAIL stall_write[%0d]: got %0b exp 0", i, IF_ID_Write_o); end
      checks++; if (pc_o !== 32'h4 || instruction_o !== 32'h1111_1111) begin failures++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h exp pc=00000004 instr=11111111", i, pc_o, instruction_o); end
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stall_req[%0d]: got %0b exp 0", i, imem_req_o); end
      if (i < 2) begin tick(); settle(); end
    end
    tick(); stall_i = 1'b0; settle();
    checks++; if (IF_ID_Write_o !== 1'b1 || pc_o !== 32'h4) begin failures++; $display("FAIL stall_release: got write=%0b pc=%h exp write=1 pc=00000004", IF_ID_Write_o, pc_o); end
    tick(); settle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin failures++; $display("FAIL stall_next_req: got req=%0b addr=%h exp req=1 addr=00000008", imem_req_o, imem_addr_o); end
  endtask

  // Request at 0x8 is live on entry.
  task automatic test_redirect_wait();
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h40; settle();
    checks++; if (Flush_o !== 1'b1) begin failures++; $display("FAIL rdw_flush: got %0b exp 1", Flush_o); end
    tick(); redirect_i = 1'b0; redirect_pc_i = 32'h0; settle();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rdw_drop_req: got %0b exp 0", imem_req_o); end
    tick(); imem_ready_i = 1'b1; imem_data_i = 32'hDEAD_BEEF; settle();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rdw_resp_req: got %0b exp 0", imem_req_o); end
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; settle();
    checks++; if (instruction_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("FAIL rdw_discard: got pc=%h instr=%h exp 0/0", pc_o, instruction_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin failures++; $display("FAIL rdw_next_req: got req=%0b addr=%h exp req=1 addr=00000040", imem_req_o, imem_addr_o); end
  endtask

  // Request at 0x40 is live on entry.
  task automatic test_redirect_ready();
    tick(); imem_ready_i = 1'b1; imem_data_i = 32'h1234_5678; redirect_i = 1'b1; redirect_pc_i = 32'h80; settle();
    checks++; if (Flush_o !== 1'b1 || imem_req_o !== 1'b0) begin failures++; $display("FAIL rdr_flush: got flush=%0b req=%0b exp 1/0", Flush_o, imem_req_o); end
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; redirect_i = 1'b0; redirect_pc_i = 32'h0; settle();
    checks++; if (instruction_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("FAIL rdr_discard: got pc=%h instr=%h exp 0/0", pc_o, instruction_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin failures++; $display("FAIL rdr_next_req: got req=%0b addr=%h exp req=1 addr=00000080", imem_req_o, imem_addr_o); end
  endtask

  // FETCH state with request at 0x80 pending; redirect suppresses it.
  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; settle();
    checks++; if (imem_req_o !== 1'b0 || Flush_o !== 1'b1) begin failures++; $display("FAIL wrap_redirect: got req=%0b flush=%0b exp 0/1", imem_req_o, Flush_o); end
    tick(); redirect_i = 1'b0; redirect_pc_i = 32'h0; settle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_aligned_req: got req=%0b addr=%h exp req=1 addr=fffffffc", imem_req_o, imem_addr_o); end
    tick(); imem_ready_i = 1'b1; imem_data_i = 32'hAAAA_5555; settle();
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; settle();
    checks++; if (pc_o !== 32'hFFFF_FFFC || instruction_o !== 32'hAAAA_5555) begin failures++; $display("FAIL wrap_deliver: got pc=%h instr=%h exp fffffffc/aaaa5555", pc_o, instruction_o); end
    tick(); settle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_next_req: got req=%0b addr=%h exp req=1 addr=00000000", imem_req_o, imem_addr_o); end
  endtask

  // Request at 0x0 is live on entry.
  task automatic test_redirect_stall();
    tick(); imem_ready_i = 1'b1; imem_data_i = 32'h0BAD_F00D; settle();
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; stall_i = 1'b1; settle();
    checks++; if (pc_o !== 32'h0 || instruction_o !== 32'h0BAD_F00D) begin failures++; $display("FAIL rds_buffered: got pc=%h instr=%h exp 00000000/0badf00d", pc_o, instruction_o); end
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h100; settle();
    checks++; if (Flush_o !== 1'b1 || IF_ID_Write_o !== 1'b0) begin failures++; $display("FAIL rds_outputs: got flush=%0b write=%0b exp 1/0", Flush_o, IF_ID_Write_o); end
    tick(); redirect_i = 1'b0; redirect_pc_i = 32'h0; stall_i = 1'b0; settle();
    checks++; if (instruction_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("FAIL rds_cleared: got pc=%h instr=%h exp 0/0", pc_o, instruction_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL rds_next_req: got req=%0b addr=%h exp req=1 addr=00000100", imem_req_o, imem_addr_o); end
  endtask

  // Request at 0x100 is live on entry; two redirects, last target wins.
  task automatic test_back_to_back_redirect();
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h200; settle();
    tick(); redirect_pc_i = 32'h300; settle();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL b2b_drop_req: got %0b exp 0", imem_req_o); end
    tick(); redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_ready_i = 1'b1; imem_data_i = 32'h5555_AAAA; settle();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL b2b_resp_req: got %0b exp 0", imem_req_o); end
    tick(); imem_ready_i = 1'b0; imem_data_i = 32'h0; settle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300 || instruction_o !== 32'h0) begin failures++; $display("FAIL b2b_next_req: got req=%0b addr=%h instr=%h exp 1/00000300/00000000", imem_req_o, imem_addr_o, instruction_o); end
  endtask

  // Request at 0x300 is live; reset while a response arrives overrides it.
  task automatic test_reset_mid();
    tick(); rst_i = 1'b1; imem_ready_i = 1'b1; imem_data_i = 32'hCAFE_0001; settle();
    checks++; if (imem_req_o !== 1'b0 || instruction_o !== 32'h0) begin failures++; $display("FAIL rstmid_hold: got req=%0b instr=%h exp 0/0", imem_req_o, instruction_o); end
    tick(); rst_i = 1'b0; imem_ready_i = 1'b0; imem_data_i = 32'h0; settle();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin failures++; $display("FAIL rstmid_restart: got req=%0b addr=%h pc=%h exp 1/00000000/00000000", imem_req_o, imem_addr_o, pc_o); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_ready();
    test_wrap();
    test_redirect_stall();
    test_back_to_back_redirect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
